// File: rtl/modulo_desserializador35_pkg.sv
// Shared constants and FSM encoding for the 35-bit serial frame loader.
// Index k of a frame always lives at bit position IDX_LAST-k, matching the 35:1 read mux.
package modulo_desserializador35_pkg;

    localparam int FRAME_BITS = 35;
    localparam int IDX_LAST   = 34;
    localparam int IDX_W      = 6;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/modulo_decod6_35.sv
// 6-to-35 one-hot write-enable decoder; idx=k drives we[34-k], the same decode
// the 35:1 mux uses to select a bit for reading. Codes 35..63 decode to all-zero.
module modulo_decod6_35
    import modulo_desserializador35_pkg::*;
(
    input  logic                  en,
    input  logic [IDX_W-1:0]      idx,
    output logic [FRAME_BITS-1:0] we
);

    always_comb begin
        we = '0;
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (en && (idx == IDX_W'(k))) begin
                we[IDX_LAST-k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modulo_desserializador35.sv
// Serial-to-parallel frame loader: assembles 35 bits in a shadow register and hands
// complete frames to a one-entry output register, stalling in HOLD while it is occupied.
//
// Handshakes: a bit moves when in_valid && in_ready on a rising clk edge; a frame
// moves when out_valid && out_ready on a rising clk edge. Neither valid depends on
// its ready, and in_ready depends only on the FSM state.
module modulo_desserializador35
    import modulo_desserializador35_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    output logic [IDX_W-1:0]      bit_index,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output state_t                state_dbg
);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [FRAME_BITS-1:0]   shadow, shadow_nxt;
    logic [FRAME_BITS-1:0]   frame_nxt;
    logic                    out_valid_nxt;

    logic                    accept;
    logic                    realign;
    logic                    complete;
    logic [IDX_W-1:0]        wr_idx;
    logic [FRAME_BITS-1:0]   wr_en;
    logic [FRAME_BITS-1:0]   base;
    logic [FRAME_BITS-1:0]   merged;

    assign in_ready  = (state == ST_FILL);
    assign bit_index = idx;
    assign state_dbg = state;

    assign accept  = in_valid && in_ready;
    // frame_start only acts while filling; in HOLD the complete frame must survive
    assign realign = frame_start && (state == ST_FILL);
    assign wr_idx  = realign ? '0 : idx;
    assign base    = realign ? '0 : shadow;

    modulo_decod6_35 u_decod (
        .en  (accept),
        .idx (wr_idx),
        .we  (wr_en)
    );

    assign merged   = (base & ~wr_en) | (wr_en & {FRAME_BITS{in_bit}});
    assign complete = accept && !realign && (idx == IDX_W'(IDX_LAST));

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        shadow_nxt    = shadow;
        frame_nxt     = frame_out;
        out_valid_nxt = out_valid;

        unique case (state)
            ST_FILL: begin
                if (realign || accept) begin
                    shadow_nxt = merged;
                end
                if (realign) begin
                    idx_nxt = accept ? IDX_W'(1) : '0;
                end else if (accept) begin
                    idx_nxt = (idx == IDX_W'(IDX_LAST)) ? '0 : idx + IDX_W'(1);
                end

                if (complete && (!out_valid || out_ready)) begin
                    frame_nxt     = merged;
                    out_valid_nxt = 1'b1;
                end else if (complete) begin
                    state_nxt = ST_HOLD;
                end else if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                end
            end

            ST_HOLD: begin
                // out_valid is necessarily 1 here; swap in the parked frame
                if (out_ready) begin
                    frame_nxt     = shadow;
                    out_valid_nxt = 1'b1;
                    state_nxt     = ST_FILL;
                end
            end

            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_FILL;
            idx       <= '0;
            shadow    <= '0;
            frame_out <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            shadow    <= shadow_nxt;
            frame_out <= frame_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_modulo_desserializador35.sv
// Bench for the 35-bit serial frame loader: bit-level reference model feeding an
// expected-frame queue, popped whenever the DUT hands a frame downstream.
module tb_modulo_desserializador35;
    import modulo_desserializador35_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic [5:0]  bit_index;
    logic [34:0] frame_out;
    logic        out_valid;
    logic        out_ready;
    state_t      state_dbg;

    logic [34:0] exp_q[$];
    logic [34:0] m_frame;
    int          m_idx;
    int          n_checks;
    int          n_fail;

    modulo_desserializador35 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .bit_index   (bit_index),
        .frame_out   (frame_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] to_frame(input logic [34:0] pat);
        logic [34:0] f;
        for (int k = 0; k < 35; k++) f[34-k] = pat[k];
        return f;
    endfunction

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_frame = '0;
        m_idx   = 0;
        exp_q.delete();
    endtask

    // driver: presents one bit (optionally with frame_start) until it is accepted
    task automatic send_bit(input logic b, input logic fs);
        int budget;
        budget      = 0;
        in_valid    = 1'b1;
        in_bit      = b;
        frame_start = fs;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            if (fs) begin
                m_frame = '0;
                m_idx   = 0;
            end
            m_frame[34-m_idx] = b;
            if (m_idx == 34) begin
                exp_q.push_back(m_frame);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_range(input logic [34:0] pat, input int lo, input int hi, input bit gaps);
        for (int k = lo; k <= hi; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_bit(pat[k], 1'b0);
        end
    endtask

    task automatic consume();
        int budget;
        budget    = 0;
        out_ready = 1'b1;
        while (out_valid && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_eq("consume_done", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    // scoreboard: a frame leaves whenever out_valid && out_ready at the next edge
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check_eq("sb_unexpected_frame", 64'(frame_out), 64'd0 - 64'd1);
            else
                check_eq("sb_frame", 64'(frame_out), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [34:0] pat_a, pat_b, pat_x;
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_bit_index", 64'(bit_index), 64'd0);
        check_eq("rst_frame_out", 64'(frame_out), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_state", 64'(state_dbg), 64'(ST_FILL));

        // alternating 1,0,1,... starting at index 0
        send_range(35'h5_5555_5555, 0, 33, 1'b0);
        check_eq("alt_not_yet_valid", 64'(out_valid), 64'd0);
        send_bit(1'b1, 1'b0);
        check_eq("alt_out_valid", 64'(out_valid), 64'd1);
        check_eq("alt_frame", 64'(frame_out), 64'h5_5555_5555);
        check_eq("alt_bit_index", 64'(bit_index), 64'd0);
        consume();

        // single one at index 34, then at index 0
        send_range(35'h4_0000_0000, 0, 34, 1'b1);
        check_eq("one_at_34", 64'(frame_out), 64'h0_0000_0001);
        consume();
        send_range(35'h0_0000_0001, 0, 34, 1'b1);
        check_eq("one_at_0", 64'(frame_out), 64'h4_0000_0000);
        consume();

        // frame 1 parked in output, frame 2 streams until HOLD
        pat_a = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        pat_b = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        send_range(pat_a, 0, 34, 1'b0);
        send_range(pat_b, 0, 34, 1'b0);
        check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        check_eq("hold_state", 64'(state_dbg), 64'(ST_HOLD));
        check_eq("hold_frame_is_a", 64'(frame_out), 64'(to_frame(pat_a)));
        check_eq("hold_bit_index", 64'(bit_index), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hold_frame_is_b", 64'(frame_out), 64'(to_frame(pat_b)));
        check_eq("hold_out_valid", 64'(out_valid), 64'd1);
        check_eq("hold_release_ready", 64'(in_ready), 64'd1);
        consume();

        // frame_start realign after 10 bits
        send_range(35'h7_FFFF_FFFF, 0, 9, 1'b1);
        check_eq("pre_fs_index", 64'(bit_index), 64'd10);
        send_bit(1'b1, 1'b1);
        check_eq("fs_bit_index", 64'(bit_index), 64'd1);
        pat_x = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        send_range(pat_x, 1, 33, 1'b1);
        check_eq("fs_not_yet_valid", 64'(out_valid), 64'd0);
        send_bit(pat_x[34], 1'b0);
        check_eq("fs_out_valid", 64'(out_valid), 64'd1);
        check_eq("fs_bit34", 64'(frame_out[34]), 64'd1);
        check_eq("fs_frame", 64'(frame_out), 64'(to_frame({pat_x[34:1], 1'b1})));

        // completion and consumption on the same edge: no bubble
        pat_b = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        send_range(pat_b, 0, 33, 1'b1);
        out_ready = 1'b1;
        send_bit(pat_b[34], 1'b0);
        check_eq("nb_frame", 64'(frame_out), 64'(to_frame(pat_b)));
        check_eq("nb_out_valid", 64'(out_valid), 64'd1);
        check_eq("nb_in_ready", 64'(in_ready), 64'd1);
        check_eq("nb_state", 64'(state_dbg), 64'(ST_FILL));
        consume();

        // asynchronous reset mid-frame
        send_range(35'h7_FFFF_FFFF, 0, 19, 1'b1);
        check_eq("pre_rst_index", 64'(bit_index), 64'd20);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_bit_index", 64'(bit_index), 64'd0);
        check_eq("arst_frame_out", 64'(frame_out), 64'd0);
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        do_reset();
        pat_a = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        send_range(pat_a, 0, 34, 1'b1);
        check_eq("post_rst_frame", 64'(frame_out), 64'(to_frame(pat_a)));
        consume();

        // a few random frames with random downstream readiness
        for (int f = 0; f < 4; f++) begin
            pat_a = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
            for (int k = 0; k < 35; k++) begin
                out_ready = ($urandom_range(0, 2) == 0);
                send_bit(pat_a[k], 1'b0);
            end
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3 && (out_valid || state_dbg == ST_HOLD); f++) consume();

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
